// File: rtl/lock_key_sender_if.sv
// Bus between the key sender and its environment: table programming port,
// run control/status, and the code/state exchange with the lock.
interface lock_key_sender_if #(
  parameter int SEQ_LEN = 8,
  parameter int CODE_W  = 4,
  parameter int STATE_W = 4
);
  localparam int ADDR_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;

  logic               prog_we;
  logic [ADDR_W-1:0]  prog_addr;
  logic [CODE_W-1:0]  prog_data;
  logic               start;
  logic [CODE_W-1:0]  code;
  logic [STATE_W-1:0] lock_state;
  logic               unlocked;
  logic               busy;
  logic               done;
  logic               fail;
  logic [1:0]         attempts;

  // Environment side: programs the table, launches runs, plays the lock.
  modport master (
    output prog_we, prog_addr, prog_data, start, lock_state, unlocked,
    input  code, busy, done, fail, attempts
  );

  // Sender side.
  modport slave (
    input  prog_we, prog_addr, prog_data, start, lock_state, unlocked,
    output code, busy, done, fail, attempts
  );
endinterface

// File: rtl/lock_key_sender.sv
// Lock key sender: streams a programmed code table into a lock one code per
// cycle, checks the lock's echoed progress one cycle later, and on mismatch
// flushes the lock back to state 0 and retries a bounded number of times.
module lock_key_sender #(
  parameter int                SEQ_LEN   = 8,
  parameter int                CODE_W    = 4,
  parameter int                STATE_W   = 4,
  parameter int                MAX_RETRY = 3,
  parameter logic [CODE_W-1:0] IDLE_CODE = CODE_W'(4'hF),
  parameter int                FLUSH_MAX = 4
) (
  input logic              clk,
  input logic              reset,
  lock_key_sender_if.slave bus
);

  localparam int ADDR_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  // idx runs 0..SEQ_LEN; the extra value marks the final "unlocked?" check cycle.
  localparam int IDX_W  = $clog2(SEQ_LEN + 1);
  // Internal attempt count reaches MAX_RETRY+1, beyond the 2-bit reported value.
  localparam int ATT_W  = ($clog2(MAX_RETRY + 2) < 2) ? 2 : $clog2(MAX_RETRY + 2);
  localparam int FL_W   = ($clog2(FLUSH_MAX) < 1) ? 1 : $clog2(FLUSH_MAX);

  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(SEQ_LEN);
  localparam logic [ATT_W-1:0] RETRY_LIMIT = ATT_W'(MAX_RETRY);
  localparam logic [ATT_W-1:0] ATT_SAT     = ATT_W'(3);
  localparam logic [FL_W-1:0]  FLUSH_LAST  = FL_W'(FLUSH_MAX - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_FLUSH,
    S_DONE,
    S_FAIL
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [ATT_W-1:0]   att_q, att_d;
  logic [FL_W-1:0]    flush_cnt_q, flush_cnt_d;
  logic [CODE_W-1:0]  code_tbl_q [SEQ_LEN];

  logic               step_ok;
  logic [CODE_W-1:0]  code_c;
  logic               busy_c;
  logic               done_c;
  logic               fail_c;
  logic [1:0]         attempts_c;

  // Code table write port; writes are dropped while a run is active or launching.
  // NOTE: the table is storage, not control state, so it carries no reset; this
  // keeps it mappable onto RAM and lets it survive a mid-run reset.
  always_ff @(posedge clk) begin
    if (bus.prog_we && !busy_c && !bus.start) begin
      code_tbl_q[bus.prog_addr] <= bus.prog_data;
    end
  end

  // State register and run counters.
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the values from before the edge regardless of order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      att_q       <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      att_q       <= att_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Next-state logic: launch, pipelined check of the lock's progress, flush/retry.
  // NOTE: every variable gets a default at the top so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    att_d       = att_q;
    flush_cnt_d = flush_cnt_q;
    step_ok     = 1'b1;

    unique case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (bus.start) begin
          state_d = S_SEND;
          idx_d   = '0;
          att_d   = ATT_W'(1);
        end
      end

      S_SEND: begin
        // The lock echoes code k as state k+1 one cycle after it was driven,
        // so while driving entry idx we verify the previous one landed.
        if (idx_q == IDX_LAST) begin
          step_ok = bus.unlocked;
        end else if (idx_q != '0) begin
          step_ok = (bus.lock_state == STATE_W'(idx_q));
        end

        if (step_ok) begin
          if (idx_q == IDX_LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else if (att_q <= RETRY_LIMIT) begin
          state_d     = S_FLUSH;
          flush_cnt_d = '0;
        end else begin
          state_d = S_FAIL;
        end
      end

      S_FLUSH: begin
        if (bus.lock_state == '0) begin
          state_d = S_SEND;
          idx_d   = '0;
          att_d   = att_q + ATT_W'(1);
        end else if (flush_cnt_q == FLUSH_LAST) begin
          state_d = S_FAIL;
        end else begin
          flush_cnt_d = flush_cnt_q + FL_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode: code stream, status flags and saturated attempt count.
  always_comb begin
    code_c     = IDLE_CODE;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    fail_c     = 1'b0;
    attempts_c = (att_q > ATT_SAT) ? 2'd3 : att_q[1:0];

    unique case (state_q)
      S_SEND: begin
        busy_c = 1'b1;
        if (idx_q != IDX_LAST) begin
          code_c = code_tbl_q[idx_q[ADDR_W-1:0]];
        end
      end
      S_FLUSH: busy_c = 1'b1;
      S_DONE:  done_c = 1'b1;
      S_FAIL:  fail_c = 1'b1;
      default: ;
    endcase
  end

  assign bus.code     = code_c;
  assign bus.busy     = busy_c;
  assign bus.done     = done_c;
  assign bus.fail     = fail_c;
  assign bus.attempts = attempts_c;

endmodule

// File: tb/tb_lock_key_sender.sv
// Bench for lock_key_sender: a behavioural lock, a table of per-cycle vectors
// for programming and a clean run, and directed sequences for retry, failure,
// dropped writes and mid-run reset.
module tb_lock_key_sender;

  localparam int SEQ_LEN = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  lock_key_sender_if #(.SEQ_LEN(SEQ_LEN), .CODE_W(4), .STATE_W(4)) bus ();

  lock_key_sender dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- behavioural lock ----------------
  logic [3:0] lock_key [SEQ_LEN];
  int         rej_idx   = -1;   // reject the correct code at this state, once
  int         never_idx = -1;   // never accept the code at this state
  bit         stuck_en  = 1'b0; // hold lock state at a nonzero value
  bit         rej_used;
  logic [3:0] lock_q;

  always @(posedge clk) begin
    if (reset) begin
      lock_q   <= 4'd0;
      rej_used <= 1'b0;
    end else if (stuck_en) begin
      lock_q <= 4'd5;
    end else if (lock_q < 4'd8 && bus.code == lock_key[lock_q[2:0]] &&
                 int'(lock_q) != never_idx &&
                 !(int'(lock_q) == rej_idx && !rej_used)) begin
      lock_q <= lock_q + 4'd1;
    end else begin
      if (lock_q < 4'd8 && int'(lock_q) == rej_idx && bus.code == lock_key[lock_q[2:0]])
        rej_used <= 1'b1;
      lock_q <= 4'd0;
    end
  end

  assign bus.lock_state = lock_q;
  assign bus.unlocked   = (lock_q == 4'd8);

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Outputs packed as {code, busy, done, fail, attempts}.
  function automatic logic [8:0] outs();
    return {bus.code, bus.busy, bus.done, bus.fail, bus.attempts};
  endfunction

  task automatic check_out(input string name, input logic [3:0] code, input logic busy,
                           input logic done, input logic fail, input logic [1:0] att);
    check(name, 32'(outs()), 32'({code, busy, done, fail, att}));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic start, input logic we, input logic [2:0] addr,
                       input logic [3:0] data);
    bus.start     = start;
    bus.prog_we   = we;
    bus.prog_addr = addr;
    bus.prog_data = data;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 3'd0, 4'd0);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  typedef struct {
    logic       start;
    logic       we;
    logic [2:0] addr;
    logic [3:0] data;
    logic [3:0] code;
    logic       busy;
    logic       done;
    logic       fail;
    logic [1:0] att;
  } vec_t;

  function automatic vec_t mk(logic start, logic we, logic [2:0] addr, logic [3:0] data,
                              logic [3:0] code, logic busy, logic done, logic fail,
                              logic [1:0] att);
    vec_t v;
    v.start = start; v.we = we; v.addr = addr; v.data = data;
    v.code = code; v.busy = busy; v.done = done; v.fail = fail; v.att = att;
    return v;
  endfunction

  vec_t vecs [19];

  initial begin
    // Vectors: program table 1..8, then a clean run with done after edge 9.
    for (int i = 0; i < 8; i++)
      vecs[i] = mk(1'b0, 1'b1, 3'(i), 4'(i + 1), 4'hF, 1'b0, 1'b0, 1'b0, 2'd0);
    vecs[8] = mk(1'b1, 1'b0, 3'd0, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0, 2'd1);
    for (int i = 9; i < 16; i++)
      vecs[i] = mk(1'b0, 1'b0, 3'd0, 4'd0, 4'(i - 7), 1'b1, 1'b0, 1'b0, 2'd1);
    vecs[16] = mk(1'b0, 1'b0, 3'd0, 4'd0, 4'hF, 1'b1, 1'b0, 1'b0, 2'd1);
    vecs[17] = mk(1'b0, 1'b0, 3'd0, 4'd0, 4'hF, 1'b0, 1'b1, 1'b0, 2'd1);
    vecs[18] = mk(1'b0, 1'b0, 3'd0, 4'd0, 4'hF, 1'b0, 1'b1, 1'b0, 2'd1);

    for (int i = 0; i < SEQ_LEN; i++) lock_key[i] = 4'(i + 1);

    // Reset state.
    do_reset();
    check_out("reset_state", 4'hF, 1'b0, 1'b0, 1'b0, 2'd0);

    // Test 1: table-driven programming and clean run.
    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].start, vecs[i].we, vecs[i].addr, vecs[i].data);
      step();
      check_out($sformatf("vec%0d", i), vecs[i].code, vecs[i].busy, vecs[i].done,
                vecs[i].fail, vecs[i].att);
    end

    // Test 2: lock rejects code 5 on the first attempt only.
    rej_idx = 4;
    do_reset();
    drive(1'b1, 1'b0, 3'd0, 4'd0);
    step();                                   // edge 0
    drive(1'b0, 1'b0, 3'd0, 4'd0);
    repeat (5) step();                        // edge 5: mismatch seen
    check_out("t2_mismatch_cycle", 4'd6, 1'b1, 1'b0, 1'b0, 2'd1);
    step();                                   // edge 6: FLUSH
    check_out("t2_flush", 4'hF, 1'b1, 1'b0, 1'b0, 2'd1);
    step();                                   // edge 7: second pass
    check_out("t2_retry_start", 4'd1, 1'b1, 1'b0, 1'b0, 2'd2);
    repeat (8) step();                        // edge 15: final check cycle
    check_out("t2_pre_done", 4'hF, 1'b1, 1'b0, 1'b0, 2'd2);
    step();                                   // edge 16
    check_out("t2_done", 4'hF, 1'b0, 1'b1, 1'b0, 2'd2);
    rej_idx = -1;

    // Test 3: lock never accepts entry 3 -> four attempts then fail.
    never_idx = 2;
    do_reset();
    drive(1'b1, 1'b0, 3'd0, 4'd0);
    step();                                   // edge 0
    drive(1'b0, 1'b0, 3'd0, 4'd0);
    repeat (3) step();                        // edge 3: mismatch
    check_out("t3_mismatch1", 4'd4, 1'b1, 1'b0, 1'b0, 2'd1);
    step();                                   // edge 4
    check_out("t3_flush1", 4'hF, 1'b1, 1'b0, 1'b0, 2'd1);
    step();                                   // edge 5
    check_out("t3_attempt2", 4'd1, 1'b1, 1'b0, 1'b0, 2'd2);
    repeat (5) step();                        // edge 10
    check_out("t3_attempt3", 4'd1, 1'b1, 1'b0, 1'b0, 2'd3);
    repeat (5) step();                        // edge 15
    check_out("t3_attempt4_sat", 4'd1, 1'b1, 1'b0, 1'b0, 2'd3);
    repeat (3) step();                        // edge 18: last mismatch
    check_out("t3_last_mismatch", 4'd4, 1'b1, 1'b0, 1'b0, 2'd3);
    step();                                   // edge 19
    check_out("t3_fail", 4'hF, 1'b0, 1'b0, 1'b1, 2'd3);
    step();
    check_out("t3_fail_sticky", 4'hF, 1'b0, 1'b0, 1'b1, 2'd3);
    never_idx = -1;

    // Test 4: lock stuck nonzero during FLUSH -> fail after 4 FLUSH cycles.
    stuck_en = 1'b1;
    do_reset();
    drive(1'b1, 1'b0, 3'd0, 4'd0);
    step();                                   // edge 0
    drive(1'b0, 1'b0, 3'd0, 4'd0);
    step();                                   // edge 1: mismatch
    check_out("t4_mismatch", 4'd2, 1'b1, 1'b0, 1'b0, 2'd1);
    repeat (4) step();                        // edge 5: 4th FLUSH cycle
    check_out("t4_flush_last", 4'hF, 1'b1, 1'b0, 1'b0, 2'd1);
    step();                                   // edge 6
    check_out("t4_fail", 4'hF, 1'b0, 1'b0, 1'b1, 2'd1);
    stuck_en = 1'b0;

    // Test 5: write with start dropped, write during SEND dropped,
    // start while busy ignored.
    do_reset();
    drive(1'b1, 1'b1, 3'd0, 4'd9);
    step();                                   // edge 0
    check_out("t5_code0_old", 4'd1, 1'b1, 1'b0, 1'b0, 2'd1);
    drive(1'b0, 1'b1, 3'd3, 4'd9);
    step();                                   // edge 1
    check_out("t5_code1", 4'd2, 1'b1, 1'b0, 1'b0, 2'd1);
    for (int k = 2; k < 8; k++) begin
      drive(k == 3, 1'b0, 3'd0, 4'd0);
      step();
      check_out($sformatf("t5_code%0d", k), 4'(k + 1), 1'b1, 1'b0, 1'b0, 2'd1);
    end
    drive(1'b0, 1'b0, 3'd0, 4'd0);
    step();
    step();                                   // edge 9
    check_out("t5_done", 4'hF, 1'b0, 1'b1, 1'b0, 2'd1);

    // Test 6: reset mid-SEND at idx 4, then restart with intact table.
    do_reset();
    drive(1'b1, 1'b0, 3'd0, 4'd0);
    step();                                   // edge 0
    drive(1'b0, 1'b0, 3'd0, 4'd0);
    repeat (4) step();                        // edge 4
    check_out("t6_idx4", 4'd5, 1'b1, 1'b0, 1'b0, 2'd1);
    reset = 1'b1;
    step();
    check_out("t6_reset_mid", 4'hF, 1'b0, 1'b0, 1'b0, 2'd0);
    reset = 1'b0;
    drive(1'b1, 1'b0, 3'd0, 4'd0);
    step();
    drive(1'b0, 1'b0, 3'd0, 4'd0);
    check_out("t6_restart0", 4'd1, 1'b1, 1'b0, 1'b0, 2'd1);
    for (int k = 1; k < 8; k++) begin
      step();
      check(.name($sformatf("t6_code%0d", k)), .act(32'(bus.code)), .exp(32'(k + 1)));
    end
    step();
    step();
    check_out("t6_done", 4'hF, 1'b0, 1'b1, 1'b0, 2'd1);

    // Restart from DONE clears done and begins a new run.
    drive(1'b1, 1'b0, 3'd0, 4'd0);
    step();
    drive(1'b0, 1'b0, 3'd0, 4'd0);
    check_out("restart_from_done", 4'd1, 1'b1, 1'b0, 1'b0, 2'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
